// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - timed two-street intersection phase scheduler with pedestrian walk
module intersection_scheduler #(
    parameter int MIN_GREEN  = 8,
    parameter int MAX_GREEN  = 32,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int WALK_CYC   = 6,
    parameter int CW         = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_ALLRED = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_ALLRED = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    localparam logic [CW-1:0] MIN_T    = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] MAX_T    = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_T = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] ALLRED_T = CW'(ALLRED_CYC - 1);
    localparam logic [CW-1:0] WALK_T   = CW'(WALK_CYC - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] timer;
    logic          next_b;
    logic          next_b_next;
    logic          min_done;
    logic          max_done;

    assign min_done = (timer >= MIN_T);
    assign max_done = (timer >= MAX_T);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= A_GREEN;
            timer    <= '0;
            ped_pend <= 1'b0;
            next_b   <= 1'b1;
        end else begin
            state  <= state_next;
            next_b <= next_b_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer != MAX_T) begin
                timer <= timer + 1'b1;
            end
            // Entering the walk clears the request even if the button is pressed that same cycle.
            if (state_next == PED_WALK && state != PED_WALK) begin
                ped_pend <= 1'b0;
            end else if (ped_req && state != PED_WALK) begin
                ped_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        next_b_next = next_b;
        case (state)
            A_GREEN: begin
                if (min_done && (tb || ped_pend) && (!ta || max_done)) begin
                    state_next = A_YELLOW;
                end
            end
            A_YELLOW: begin
                if (timer == YELLOW_T) begin
                    state_next = A_ALLRED;
                end
            end
            A_ALLRED: begin
                if (timer == ALLRED_T) begin
                    next_b_next = 1'b1;
                    state_next  = ped_pend ? PED_WALK : B_GREEN;
                end
            end
            B_GREEN: begin
                if (min_done && (ta || ped_pend) && (!tb || max_done)) begin
                    state_next = B_YELLOW;
                end
            end
            B_YELLOW: begin
                if (timer == YELLOW_T) begin
                    state_next = B_ALLRED;
                end
            end
            B_ALLRED: begin
                if (timer == ALLRED_T) begin
                    next_b_next = 1'b0;
                    state_next  = ped_pend ? PED_WALK : A_GREEN;
                end
            end
            PED_WALK: begin
                if (timer == WALK_T) begin
                    state_next = next_b ? B_GREEN : A_GREEN;
                end
            end
            default: state_next = A_GREEN;
        endcase
    end

    always_comb begin
        la   = RED;
        lb   = RED;
        walk = 1'b0;
        case (state)
            A_GREEN:  la   = GREEN;
            A_YELLOW: la   = YELLOW;
            B_GREEN:  lb   = GREEN;
            B_YELLOW: lb   = YELLOW;
            PED_WALK: walk = 1'b1;
            default:  ;
        endcase
    end

    assign state_o = state;

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Timed phase scheduler for a two-street intersection with pedestrian crossing. It drives the A and B light outputs through green, yellow and all-red clearance phases with cycle-accurate dwell counters. It arbitrates street demand (`ta`, `tb`) and a latched pedestrian request, enforcing minimum and maximum green times. It sits between the road and pedestrian sensors and the lamp drivers, and replaces the untimed two-street sequencer.

## Interface
- `MIN_GREEN`, 8: minimum green dwell, in cycles.
- `MAX_GREEN`, 32: green dwell after which the phase yields to competing demand even if its own street is still busy.
- `YELLOW_CYC`, 3: yellow dwell, in cycles.
- `ALLRED_CYC`, 2: all-red clearance dwell, in cycles.
- `WALK_CYC`, 6: pedestrian walk dwell, in cycles.
- `CW`, 6: phase timer width. Must hold `MAX_GREEN-1`.
- Parameter constraints: every dwell ≥1, and `MIN_GREEN` ≤ `MAX_GREEN`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ta`  in  1  traffic present on street A (level).
- `tb`  in  1  traffic present on street B (level).
- `ped_req`  in  1  pedestrian button; any cycle high sets the pending flag.
- `la`  out  2  street A light: GREEN=2'b00, YELLOW=2'b01, RED=2'b10.
- `lb`  out  2  street B light, same encoding.
- `walk`  out  1  pedestrian walk lamp.
- `ped_pend`  out  1  latched pedestrian request not yet served.
- `state_o`  out  3  current state, for debug and verification.

## Operation
- States and their `state_o` codes:
  - A_GREEN=0, A_YELLOW=1, A_ALLRED=2
  - B_GREEN=3, B_YELLOW=4, B_ALLRED=5
  - PED_WALK=6
  - Code 7 is unused and recovers to A_GREEN on the next edge.
- Phase timer: cleared to 0 on every state change, incremented each cycle otherwise, saturating at `MAX_GREEN-1`.
- Competing demand:
  - In A_GREEN: `tb | ped_pend`.
  - In B_GREEN: `ta | ped_pend`.
- A_GREEN → A_YELLOW when all of the following hold:
  - timer ≥ `MIN_GREEN-1`,
  - competing demand is present,
  - and (`!ta` or timer ≥ `MAX_GREEN-1`).
- With no competing demand, A_GREEN rests indefinitely.
- A_YELLOW → A_ALLRED at timer = `YELLOW_CYC-1`.
- A_ALLRED, at timer = `ALLRED_CYC-1`:
  - goes to PED_WALK if `ped_pend`,
  - else to B_GREEN.
- B-side transitions are symmetric, with `ta`/`tb` swapped. B_ALLRED targets PED_WALK or A_GREEN.
- PED_WALK, at timer = `WALK_CYC-1`: goes to the green of the street opposite the one that last cleared. A 1-bit `next_b` register records this, written on leaving A_ALLRED or B_ALLRED.
- `ped_pend` behaviour:
  - Set by `ped_req` in any state except PED_WALK.
  - Cleared on the edge entering PED_WALK.
  - `ped_req` during PED_WALK is ignored.
  - If `ped_req` arrives in the same cycle as the transition into PED_WALK, the clear wins and the request is dropped.
- Outputs are Moore-decoded from the state register:
  - `la`: GREEN in A_GREEN, YELLOW in A_YELLOW, RED otherwise.
  - `lb`: GREEN in B_GREEN, YELLOW in B_YELLOW, RED otherwise.
  - `walk`: 1 only in PED_WALK.
- Safety invariant: `la` and `lb` are never both non-RED, and `walk` never coincides with a non-RED light.

## Timing
- Reset (`rst_n` low at a rising edge) forces:
  - state A_GREEN, timer 0, `ped_pend`=0, `next_b`=1,
  - hence `la`=00, `lb`=10, `walk`=0, `ped_pend`=0, `state_o`=0.
- Reset mid-phase takes effect at that edge, from any state. No partial yellow or walk completes.
- Outputs change only on the edge that changes state, so there is zero combinational path from inputs to outputs.
- Dwell times:
  - Yellow lasts exactly `YELLOW_CYC` cycles.
  - All-red lasts exactly `ALLRED_CYC` cycles.
  - Walk lasts exactly `WALK_CYC` cycles.
  - Green lasts at least `MIN_GREEN` cycles, and at most `MAX_GREEN` cycles once competing demand is continuous.
- Inputs are sampled every cycle. Demand that drops before `MIN_GREEN` expires does not cause a transition.
- Simultaneous `ta` and `tb` with `ta` never dropping: A_GREEN holds exactly `MAX_GREEN` cycles, then yields.

## Test plan
- Reset, then `ta`=`tb`=`ped_req`=0 for 100 cycles → `state_o`=0, `la`=00, `lb`=10, `walk`=0 throughout.
- Release reset at cycle 0 with `tb`=1, `ta`=0 → `la`=00 for cycles 0–7, 01 for cycles 8–10, 10 from cycle 11; `lb`=00 from cycle 13.
- `ta`=`tb`=1 held → A green for 32 cycles, yellow 3, all-red 2, then B green for 32 cycles; lights alternate indefinitely and are never both non-RED.
- One-cycle `ped_req` at cycle 2 with `ta`=`tb`=0 → `ped_pend`=1 from cycle 3; A green through cycle 7, yellow 8–10, all-red 11–12; `walk`=1 for cycles 13–18 with `ped_pend`=0 from cycle 13; `lb`=00 from cycle 19.
- `ped_req` held high throughout PED_WALK → `ped_pend` stays 0 during the walk and sets on the first cycle after the walk ends.
- `rst_n` low during A_YELLOW with `tb`=1 → on the next edge `state_o`=0, `la`=00, `ped_pend`=0; minimum green restarts from timer 0.
